// File: rtl/fifo_ser_pkg.sv
// fifo_ser_pkg: shared state encoding and sizing helper for fifo_serializer.
// The PAR state is only reachable when FIFO_SER_PARITY_EN is defined.
package fifo_ser_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PAR} ser_state_t;

  function automatic int bitcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// ser_shift_reg: parallel-load, shift-left register presenting its MSB, plus
// the even parity of the most recently loaded word.
module ser_shift_reg #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [width-1:0] i_din,
  output logic             o_msb,
  output logic             o_parity
);

  logic [width-1:0] r_shreg;
  logic             r_parity;

  // Parity is captured at load time because the register contents are destroyed by shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg  <= '0;
      r_parity <= 1'b0;
    end else if (i_load) begin
      r_shreg  <= i_din;
      r_parity <= ^i_din;
    end else if (i_shift) begin
      r_shreg  <= {r_shreg[width-2:0], 1'b0};
    end
  end

  assign o_msb    = r_shreg[width-1];
  assign o_parity = r_parity;

endmodule

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from fifo_flops and sends them MSB-first over a 1-bit ready/valid port.
// Define FIFO_SER_PARITY_EN to append an even-parity bit to every frame.
module fifo_serializer
  import fifo_ser_pkg::*;
#(
  parameter int width = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] Din,
  input  logic             pndng,
  output logic             pop,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int            BW       = bitcnt_w(width);
  localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [BW-1:0]    r_bitcnt;
  logic [CNT_W-1:0] r_word_count;
  logic             r_pop;
  logic             w_valid;
  logic             w_accept;
  logic             w_data_end;
  logic             w_frame_done;
  logic             w_load;
  logic             w_shift;
  logic             w_msb;
  logic             w_parity;

  assign w_valid    = (r_state == SHIFT) || (r_state == PAR);
  assign w_accept   = w_valid && ser_ready;
  assign w_load     = (r_state == LOAD);
  assign w_shift    = (r_state == SHIFT) && w_accept;
  assign w_data_end = w_shift && (r_bitcnt == LAST_BIT);

`ifdef FIFO_SER_PARITY_EN
  assign w_frame_done = (r_state == PAR) && w_accept;
  assign ser_last     = (r_state == PAR);
`else
  assign w_frame_done = w_data_end;
  assign ser_last     = (r_state == SHIFT) && (r_bitcnt == LAST_BIT);
`endif

  ser_shift_reg #(.width(width)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_din    (Din),
    .o_msb    (w_msb),
    .o_parity (w_parity)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (pndng) w_state_nxt = LOAD;
      LOAD:  w_state_nxt = SHIFT;
`ifdef FIFO_SER_PARITY_EN
      SHIFT: if (w_data_end) w_state_nxt = PAR;
      PAR:   ;
`else
      SHIFT: ;
      default: w_state_nxt = IDLE;
`endif
    endcase
    // A finished frame chains straight into the next load when the FIFO still has data.
    if (w_frame_done) w_state_nxt = pndng ? LOAD : IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pop        <= 1'b0;
      r_bitcnt     <= '0;
      r_word_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pop   <= (w_state_nxt == LOAD);
      if (w_load) begin
        r_bitcnt <= '0;
      end else if (w_shift) begin
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_frame_done) r_word_count <= r_word_count + 1'b1;
    end
  end

  assign pop        = r_pop;
  assign ser_valid  = w_valid;
  assign ser_out    = ((r_state == SHIFT) && w_msb) || ((r_state == PAR) && w_parity);
  assign ser_first  = (r_state == SHIFT) && (r_bitcnt == '0);
  assign busy       = (r_state != IDLE);
  assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed bench with a FIFO model and a bit-level scoreboard;
// a second CNT_W=4 instance runs in lockstep to observe word_count wrap.
module tb_fifo_serializer;

  localparam int W = 16;
`ifdef FIFO_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = PAR_EN ? W + 1 : W;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  Din;
  logic          pndng;
  logic          ser_ready;
  logic          pop, ser_out, ser_valid, ser_first, ser_last, busy;
  logic [15:0]   word_count;
  logic          pop4, ser_out4, ser_valid4, ser_first4, ser_last4, busy4;
  logic [3:0]    word_count4;

  logic [W-1:0]  fifo_q[$];
  exp_t          exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_pop    = 0;
  int n_acc    = 0;
  int n_bubble = 0;
  logic        prev_pop = 1'b0;
  logic        s_pop, s_valid, s_out, s_first, s_last, s_busy;
  logic [15:0] s_wc;
  logic [3:0]  s_wc4;

  fifo_serializer #(.width(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Din(Din), .pndng(pndng), .pop(pop),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_first(ser_first), .ser_last(ser_last), .busy(busy), .word_count(word_count)
  );

  fifo_serializer #(.width(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .Din(Din), .pndng(pndng), .pop(pop4),
    .ser_out(ser_out4), .ser_valid(ser_valid4), .ser_ready(ser_ready),
    .ser_first(ser_first4), .ser_last(ser_last4), .busy(busy4), .word_count(word_count4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    pndng = (fifo_q.size() != 0);
    Din   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    fifo_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) begin
      e.b = w[i];
      e.f = (i == W - 1);
      e.l = !PAR_EN && (i == 0);
      exp_q.push_back(e);
    end
    if (PAR_EN) begin
      e.b = ^w;
      e.f = 1'b0;
      e.l = 1'b1;
      exp_q.push_back(e);
    end
    refresh();
  endtask

  // One clock: sample at negedge, score, then let the FIFO model react to pop after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_pop = pop; s_valid = ser_valid; s_out = ser_out; s_first = ser_first;
    s_last = ser_last; s_busy = busy; s_wc = word_count; s_wc4 = word_count4;
    if (s_pop) begin
      n_pop++;
      chk("pop_twice", 32'(prev_pop), 32'd0);
      chk("pop_empty", 32'(fifo_q.size() != 0), 32'd1);
    end
    prev_pop = s_pop;
    if (s_busy && !s_valid) n_bubble++;
    if (!s_valid) chk("idle_flags", 32'({s_first, s_last, s_out}), 32'd0);
    if (s_valid) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("bit", 32'(s_out), 32'(e.b));
        chk("first", 32'(s_first), 32'(e.f));
        chk("last", 32'(s_last), 32'(e.l));
        if (ser_ready) begin
          void'(exp_q.pop_front());
          n_acc++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (s_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      cycle();
      if (!s_busy && exp_q.size() == 0 && fifo_q.size() == 0) break;
    end
    chk("idle_timeout", 32'(k < budget), 32'd1);
  endtask

  initial begin
    int base_pop, base_acc, k;
    rst = 1'b0; ser_ready = 1'b0; Din = '0; pndng = 1'b0;

    // 1. reset hold with data pending
    fifo_q.push_back(16'h1234);
    refresh();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rst_pop", 32'(s_pop), 32'd0);
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_wc", 32'(s_wc), 32'd0);
    end
    fifo_q.delete();
    refresh();
    cycle();
    rst = 1'b1;
    cycle();

    // 2. single word, latency and contents
    ser_ready = 1'b1;
    base_pop = n_pop;
    push_word(16'hA5C3);
    cycle();
    chk("lat_idle_pop", 32'(s_pop), 32'd0);
    cycle();
    chk("lat_pop", 32'(s_pop), 32'd1);
    chk("lat_load_valid", 32'(s_valid), 32'd0);
    cycle();
    chk("lat_valid", 32'(s_valid), 32'd1);
    chk("lat_first", 32'(s_first), 32'd1);
    run_until_idle(60);
    chk("single_pops", 32'(n_pop - base_pop), 32'd1);
    chk("single_wc", 32'(s_wc), 32'd1);

    // 3. backpressure with ready pattern 1,0,0
    base_acc = n_acc;
    push_word(16'h8001);
    for (k = 0; k < 200; k++) begin
      ser_ready = (k % 3 == 0);
      cycle();
      if (!s_busy && exp_q.size() == 0 && fifo_q.size() == 0) break;
    end
    chk("bp_timeout", 32'(k < 200), 32'd1);
    chk("bp_accepts", 32'(n_acc - base_acc), 32'(FRAME));
    chk("bp_wc", 32'(s_wc), 32'd2);

    // 4. back-to-back from a full FIFO
    ser_ready = 1'b1;
    base_pop = n_pop;
    n_bubble = 0;
    for (int i = 0; i < 8; i++) push_word(16'h1111 * 16'(i + 1) ^ 16'h8421);
    run_until_idle(400);
    chk("b2b_pops", 32'(n_pop - base_pop), 32'd8);
    chk("b2b_bubbles", 32'(n_bubble), 32'd8);
    chk("b2b_wc", 32'(s_wc), 32'd10);
    cycle();
    chk("b2b_busy", 32'(s_busy), 32'd0);

    // 5. asynchronous reset mid-frame
    base_acc = n_acc;
    push_word(16'hFFFF);
    for (k = 0; k < 50 && (n_acc - base_acc) < 5; k++) cycle();
    chk("mid_reach5", 32'(n_acc - base_acc), 32'd5);
    chk("mid_out_before", 32'(ser_out), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_outs", 32'({pop, ser_valid, ser_out, ser_first, ser_last, busy}), 32'd0);
    chk("arst_wc", 32'(word_count), 32'd0);
    exp_q.delete();
    fifo_q.delete();
    refresh();
    prev_pop = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    push_word(16'h3C5A);
    run_until_idle(60);
    chk("post_rst_wc", 32'(s_wc), 32'd1);

    // 6. word_count wrap on the CNT_W=4 instance
    rst = 1'b0;
    #1;
    prev_pop = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    for (int i = 0; i < 17; i++) push_word(W'($urandom));
    run_until_idle(800);
    chk("wrap_wc16", 32'(s_wc), 32'd17);
    chk("wrap_wc4", 32'(s_wc4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
